instr_encoder_loader: RTL

Inverse of the control-unit decode path. Accepts symbolic instruction descriptors (op class, cmd, imm flag, registers, immediate) over a valid/ready handshake and encodes each one into the 32-bit instruction word that the decode stage consumes. It rejects illegal encodings and writes the legal words sequentially into the instruction memory write port, starting at a programmable base address. It sits between the host/debug program-load path and instruction memory.

---
 rtl/instr_encoder_loader_pkg.sv | 42 ++++
 rtl/instr_field_packer.sv | 43 ++++
 rtl/instr_encoder_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared instruction-format definitions for the encoder/loader and the decode stage.
// Field positions live here so encode and decode always agree on the word layout.
package instr_encoder_loader_pkg;

    typedef enum logic [1:0] {
        OP_PROC = 2'b00,
        OP_MEM  = 2'b01,
        OP_FLOW = 2'b10,
        OP_ILL  = 2'b11
    } op_t;

    localparam logic [4:0] CMD_COS  = 5'b01100;
    localparam logic       WITH_IMM = 1'b1;

    localparam int OP_LSB   = 30;
    localparam int CMD_LSB  = 25;
    localparam int IMM_BIT  = 24;
    localparam int RD_LSB   = 20;
    localparam int RN_LSB   = 16;
    localparam int RM_LSB   = 12;
    localparam int MCMD_LSB = 28;
    localparam int LINK_BIT = 29;

    typedef struct packed {
        op_t         op;
        logic [4:0]  cmd;
        logic        imm;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [23:0] imm_val;
    } instr_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_FULL,
        ST_ERR
    } state_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: symbolic descriptor to 32-bit instruction word plus legality flag.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  instr_desc_t desc,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        word[OP_LSB +: 2] = desc.op;
        case (desc.op)
            OP_PROC: begin
                word[CMD_LSB +: 5] = desc.cmd;
                word[IMM_BIT]      = desc.imm;
                word[RD_LSB +: 4]  = desc.rd;
                word[RN_LSB +: 4]  = desc.rn;
                if (desc.imm == WITH_IMM)
                    word[15:0] = desc.imm_val[15:0];
                else
                    word[RM_LSB +: 4] = desc.rm;
                illegal = (desc.cmd > CMD_COS);
            end
            OP_MEM: begin
                // memory ops are always immediate; in_imm is ignored
                word[MCMD_LSB +: 2] = desc.cmd[1:0];
                word[RD_LSB +: 4]   = desc.rd;
                word[RN_LSB +: 4]   = desc.rn;
                word[15:0]          = desc.imm_val[15:0];
                illegal             = |desc.cmd[4:2];
            end
            OP_FLOW: begin
                word[LINK_BIT] = desc.cmd[0];
                word[23:0]     = desc.imm_val;
                illegal        = |desc.cmd[4:1];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes descriptors and writes legal words sequentially into instruction memory.
// state | meaning: IDLE reset/no session, LOAD accepting, DONE last written, FULL memory end hit, ERR illegal seen
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        in_op,
    input  logic [4:0]        in_cmd,
    input  logic              in_imm,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [23:0]       in_imm_val,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              error,
    output logic [ADDR_W-1:0] err_index,
    output logic [ADDR_W:0]   word_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    instr_desc_t       desc;
    logic [31:0]       word;
    logic              illegal;
    logic              accept;
    logic              at_end;

    assign desc = '{op: op_t'(in_op), cmd: in_cmd, imm: in_imm, rd: in_rd,
                    rn: in_rn, rm: in_rm, imm_val: in_imm_val};

    instr_field_packer u_packer (
        .desc    (desc),
        .word    (word),
        .illegal (illegal)
    );

    assign accept = in_valid && (state_q == ST_LOAD);
    assign at_end = (addr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FULL, ST_ERR: begin
                if (start)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept) begin
                    if (illegal)
                        state_d = ST_ERR;
                    else if (in_last)
                        state_d = ST_DONE;
                    else if (at_end)
                        state_d = ST_FULL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // the index of a rejected descriptor equals the count of legal words written before it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err_index  <= '0;
            word_count <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start && (state_q != ST_LOAD)) begin
                addr_q     <= base_addr;
                word_count <= '0;
                err_index  <= '0;
            end else if (accept) begin
                if (illegal) begin
                    err_index <= word_count[ADDR_W-1:0];
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= addr_q;
                    imem_wdata <= word;
                    word_count <= word_count + 1'b1;
                    if (!at_end)
                        addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q == ST_LOAD);
    assign done     = (state_q == ST_DONE);
    assign overflow = (state_q == ST_FULL);
    assign error    = (state_q == ST_ERR);

endmodule
